// File: rtl/mod_bram_writer_if.sv
// Stream-in and BRAM-write bus of the modulation buffer writer.
// The slave modport is the writer's view; master is the producer/BRAM side.
interface mod_bram_writer_if;
  logic        START;
  logic [7:0]  DIN;
  logic        DIN_VALID;
  logic        DIN_LAST;
  logic        DIN_READY;
  logic        BRAM_WE;
  logic [1:0]  BRAM_SELECT;
  logic [13:0] BRAM_ADDR;
  logic [15:0] BRAM_DATA;
  logic [15:0] MOD_CYCLE;
  logic        BUSY;
  logic        DONE;
  logic        OVERFLOW;

  modport slave (
    input  START, DIN, DIN_VALID, DIN_LAST,
    output DIN_READY, BRAM_WE, BRAM_SELECT, BRAM_ADDR, BRAM_DATA,
           MOD_CYCLE, BUSY, DONE, OVERFLOW
  );

  modport master (
    output START, DIN, DIN_VALID, DIN_LAST,
    input  DIN_READY, BRAM_WE, BRAM_SELECT, BRAM_ADDR, BRAM_DATA,
           MOD_CYCLE, BUSY, DONE, OVERFLOW
  );
endinterface

// File: rtl/mod_bram_writer.sv
// Modulation BRAM writer: packs a byte stream two samples per 16-bit word,
// writes the words through a 14-bit address window, reprograms the page
// offset register whenever the window has to move, and publishes the
// sample count minus one as MOD_CYCLE when the sequence ends.
module mod_bram_writer #(
  parameter logic [1:0]  BRAM_CONFIG_SELECT        = 2'h0,
  parameter logic [1:0]  BRAM_MOD_SELECT           = 2'h1,
  parameter logic [13:0] MOD_BRAM_ADDR_OFFSET_ADDR = 14'h0006,
  parameter int          MAX_SAMPLES               = 65536
) (
  input logic              CLK,
  input logic              RST,
  mod_bram_writer_if.slave bus
);

  localparam logic [16:0] MAX_COUNT = 17'(MAX_SAMPLES);

  typedef enum logic [2:0] {
    IDLE,
    SET_PAGE,
    STREAM,
    FLUSH,
    FIN
  } state_t;

  state_t      state, state_n;
  logic [16:0] count, count_n;
  logic [16:0] count_inc;
  logic [15:0] page, page_n;
  logic [7:0]  held, held_n;
  logic        we, we_n;
  logic [1:0]  sel, sel_n;
  logic [13:0] addr, addr_n;
  logic [15:0] data, data_n;
  logic [15:0] mod_cycle, mod_cycle_n;
  logic        done, done_n;
  logic        overflow, overflow_n;
  logic        accept;

  // Next-state and next-output logic; every BRAM output is computed here and
  // registered below, so each write appears one cycle after its cause.
  always_comb begin
    state_n     = state;
    count_n     = count;
    page_n      = page;
    held_n      = held;
    we_n        = 1'b0;
    sel_n       = sel;
    addr_n      = addr;
    data_n      = data;
    mod_cycle_n = mod_cycle;
    done_n      = 1'b0;
    overflow_n  = overflow;
    accept      = (state == STREAM) && bus.DIN_VALID;
    count_inc   = count + 17'd1;

    case (state)
      IDLE: begin
        if (bus.START) begin
          count_n    = '0;
          page_n     = '0;
          overflow_n = 1'b0;
          state_n    = SET_PAGE;
        end
      end

      SET_PAGE: begin
        we_n    = 1'b1;
        sel_n   = BRAM_CONFIG_SELECT;
        addr_n  = MOD_BRAM_ADDR_OFFSET_ADDR;
        data_n  = page;
        state_n = STREAM;
      end

      STREAM: begin
        if (accept) begin
          if (count == MAX_COUNT) begin
            overflow_n = 1'b1;
          end else begin
            count_n = count_inc;
            if (!count[0]) begin
              held_n = bus.DIN;
            end else begin
              we_n   = 1'b1;
              sel_n  = BRAM_MOD_SELECT;
              addr_n = count[14:1];
              data_n = {bus.DIN, held};
              // Window full and more samples still fit: move to the next page.
              if ((count[14:1] == 14'h3FFF) && !bus.DIN_LAST && (count_inc < MAX_COUNT)) begin
                page_n  = page + 16'd1;
                state_n = SET_PAGE;
              end
            end
          end
          if (bus.DIN_LAST) begin
            state_n = count_n[0] ? FLUSH : FIN;
          end
        end
      end

      FLUSH: begin
        we_n    = 1'b1;
        sel_n   = BRAM_MOD_SELECT;
        addr_n  = count[14:1];
        data_n  = {8'h00, held};
        state_n = FIN;
      end

      FIN: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // DONE and MOD_CYCLE are loaded on entry so both are valid during FIN.
    if (state_n == FIN) begin
      done_n      = 1'b1;
      mod_cycle_n = count_n[15:0] - 16'd1;
    end
  end

  // State and registered outputs, cleared by the synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      count     <= '0;
      page      <= '0;
      held      <= '0;
      we        <= 1'b0;
      sel       <= '0;
      addr      <= '0;
      data      <= '0;
      mod_cycle <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      page      <= page_n;
      held      <= held_n;
      we        <= we_n;
      sel       <= sel_n;
      addr      <= addr_n;
      data      <= data_n;
      mod_cycle <= mod_cycle_n;
      done      <= done_n;
      overflow  <= overflow_n;
    end
  end

  assign bus.DIN_READY   = (state == STREAM);
  assign bus.BUSY        = (state != IDLE);
  assign bus.BRAM_WE     = we;
  assign bus.BRAM_SELECT = sel;
  assign bus.BRAM_ADDR   = addr;
  assign bus.BRAM_DATA   = data;
  assign bus.MOD_CYCLE   = mod_cycle;
  assign bus.DONE        = done;
  assign bus.OVERFLOW    = overflow;

endmodule

// File: tb/tb_mod_bram_writer.sv
// Self-checking bench for mod_bram_writer: table-driven sequences, hand
// written corner cases and random runs checked against a write-list model.
module tb_mod_bram_writer;

  localparam int MAX  = 65536;
  localparam int PAGE = 16384;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mod_bram_writer_if bus ();

  mod_bram_writer #(.MAX_SAMPLES(MAX)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct {
    int len;
    bit gaps;
    bit spam;
    int exp_cycle;
    bit exp_ovf;
    int exp_words;
    int exp_cfg;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  bytes [0:MAX];
  logic [31:0] wr_q [$];
  logic [31:0] exp_q [$];
  int          done_cnt;
  logic [15:0] done_cycle;

  // Record every BRAM write as {select, addr, data} and every DONE pulse.
  always @(negedge clk) begin
    if (bus.BRAM_WE) wr_q.push_back({bus.BRAM_SELECT, bus.BRAM_ADDR, bus.BRAM_DATA});
    if (bus.DONE) begin
      done_cnt   = done_cnt + 1;
      done_cycle = bus.MOD_CYCLE;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected write list straight from the packing rules: one page-offset
  // write up front, then word k = {byte 2k+1, byte 2k} at page k/16384,
  // address k%16384, with a new page-offset write before each page start.
  task automatic build_model(input int len);
    int eff;
    logic [7:0] lo, hi;
    eff = (len < MAX) ? len : MAX;
    exp_q.delete();
    exp_q.push_back({2'h0, 14'h0006, 16'h0000});
    for (int k = 0; 2 * k < eff; k++) begin
      if (k > 0 && (k % PAGE) == 0) exp_q.push_back({2'h0, 14'h0006, 16'(k / PAGE)});
      lo = bytes[2 * k];
      hi = (2 * k + 1 < eff) ? bytes[2 * k + 1] : 8'h00;
      exp_q.push_back({2'h1, 14'(k % PAGE), hi, lo});
    end
  endtask

  task automatic applyStimulus(input int len, input bit gaps, input bit spam,
                               input bit abort_mid, output int stalls);
    int guard;
    int g;
    wr_q.delete();
    done_cnt = 0;
    stalls   = 0;
    @(negedge clk);
    bus.START     = 1'b1;
    bus.DIN_VALID = 1'b1;
    bus.DIN       = bytes[0];
    bus.DIN_LAST  = 1'b0;
    @(negedge clk);
    bus.START = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (gaps && i > 0) begin
        g = $urandom_range(0, 3);
        for (int j = 0; j < g; j++) begin
          bus.DIN_VALID = 1'b0;
          bus.DIN_LAST  = 1'b1;
          bus.DIN       = 8'($urandom);
          bus.START     = spam;
          @(negedge clk);
        end
      end
      bus.DIN_VALID = 1'b1;
      bus.DIN       = bytes[i];
      bus.DIN_LAST  = (i == len - 1) && !abort_mid;
      bus.START     = spam && (i < len - 1) && ($urandom_range(0, 1) == 1);
      guard = 0;
      while (!bus.DIN_READY) begin
        if (i > 0) stalls++;
        guard++;
        if (guard > 8) begin
          check("ready_timeout", 32'd1, 32'd0);
          bus.DIN_VALID = 1'b0;
          bus.DIN_LAST  = 1'b0;
          bus.START     = 1'b0;
          return;
        end
        @(negedge clk);
      end
      @(negedge clk);
    end
    bus.DIN_VALID = 1'b0;
    bus.DIN_LAST  = 1'b0;
    bus.START     = 1'b0;
    if (abort_mid) return;
    guard = 0;
    while (bus.BUSY) begin
      guard++;
      if (guard > 10) begin
        check("idle_timeout", 32'd1, 32'd0);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string tag, input int len, input int exp_cycle,
                             input bit exp_ovf, input int exp_words, input int exp_cfg,
                             input int stalls);
    int nm, nc;
    nm = 0;
    nc = 0;
    foreach (wr_q[i]) begin
      if (wr_q[i][31:30] == 2'h1) nm++;
      else if (wr_q[i][31:30] == 2'h0) nc++;
    end
    check($sformatf("%s done_count", tag), done_cnt, 1);
    check($sformatf("%s mod_cycle_at_done", tag), {16'h0, done_cycle}, exp_cycle);
    check($sformatf("%s mod_cycle_held", tag), {16'h0, bus.MOD_CYCLE}, exp_cycle);
    check($sformatf("%s overflow", tag), {31'h0, bus.OVERFLOW}, {31'h0, exp_ovf});
    check($sformatf("%s mod_writes", tag), nm, exp_words);
    check($sformatf("%s cfg_writes", tag), nc, exp_cfg);
    check($sformatf("%s stall_cycles", tag), stalls, exp_cfg - 1);
    build_model(len);
    check($sformatf("%s write_list_size", tag), wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("[TB] FAIL %s write[%0d]: got 0x%0h, expected 0x%0h", tag, i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  vec_t vecs [6];
  int   stalls;
  int   len;

  initial begin
    vecs[0] = '{1,  0, 0, 0,  0, 1, 1};
    vecs[1] = '{2,  0, 0, 1,  0, 1, 1};
    vecs[2] = '{5,  1, 0, 4,  0, 3, 1};
    vecs[3] = '{8,  1, 1, 7,  0, 4, 1};
    vecs[4] = '{13, 1, 1, 12, 0, 7, 1};
    vecs[5] = '{6,  0, 1, 5,  0, 3, 1};

    rst           = 1'b1;
    bus.START     = 1'b0;
    bus.DIN       = 8'h00;
    bus.DIN_VALID = 1'b0;
    bus.DIN_LAST  = 1'b0;
    done_cnt      = 0;
    done_cycle    = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'h0, bus.BUSY}, 0);
    check("reset din_ready", {31'h0, bus.DIN_READY}, 0);
    check("reset bram_we", {31'h0, bus.BRAM_WE}, 0);
    check("reset bram_select", {30'h0, bus.BRAM_SELECT}, 0);
    check("reset bram_addr", {18'h0, bus.BRAM_ADDR}, 0);
    check("reset bram_data", {16'h0, bus.BRAM_DATA}, 0);
    check("reset mod_cycle", {16'h0, bus.MOD_CYCLE}, 0);
    check("reset done", {31'h0, bus.DONE}, 0);
    check("reset overflow", {31'h0, bus.OVERFLOW}, 0);
    rst = 1'b0;

    // Four bytes, even length.
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    applyStimulus(4, 0, 0, 0, stalls);
    check("even cfg_write", wr_q[0], {2'h0, 14'h0006, 16'h0000});
    check("even word0", wr_q[1], {2'h1, 14'h0000, 16'h2211});
    check("even word1", wr_q[2], {2'h1, 14'h0001, 16'h4433});
    checkOutput("even", 4, 3, 0, 2, 1, stalls);

    // Three bytes, trailing byte flushed.
    bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC;
    applyStimulus(3, 0, 0, 0, stalls);
    check("odd word0", wr_q[1], {2'h1, 14'h0000, 16'hBBAA});
    check("odd flush", wr_q[2], {2'h1, 14'h0001, 16'h00CC});
    checkOutput("odd", 3, 2, 0, 2, 1, stalls);

    // Reset after five bytes of an unfinished sequence.
    for (int i = 0; i < 5; i++) bytes[i] = 8'($urandom);
    applyStimulus(5, 0, 0, 1, stalls);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", {31'h0, bus.BUSY}, 0);
    check("midrst bram_we", {31'h0, bus.BRAM_WE}, 0);
    check("midrst mod_cycle", {16'h0, bus.MOD_CYCLE}, 0);
    check("midrst din_ready", {31'h0, bus.DIN_READY}, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
    applyStimulus(4, 0, 0, 0, stalls);
    checkOutput("after_rst", 4, 3, 0, 2, 1, stalls);

    // Table of lengths with gaps and ignored START pulses.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].len; i++) bytes[i] = 8'($urandom);
      applyStimulus(vecs[v].len, vecs[v].gaps, vecs[v].spam, 0, stalls);
      checkOutput($sformatf("vec%0d", v), vecs[v].len, vecs[v].exp_cycle, vecs[v].exp_ovf,
                  vecs[v].exp_words, vecs[v].exp_cfg, stalls);
    end

    // Random lengths, gaps and START spam.
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 60);
      for (int i = 0; i < len; i++) bytes[i] = 8'($urandom);
      applyStimulus(len, 1, 1, 0, stalls);
      checkOutput($sformatf("rand%0d", r), len, len - 1, 0, (len + 1) / 2, 1, stalls);
    end

    // Full buffer plus one: page crossing, then overflow.
    for (int i = 0; i <= MAX; i++) bytes[i] = 8'($urandom);
    applyStimulus(MAX + 1, 0, 0, 0, stalls);
    check("big last_word_page0 addr", {18'h0, wr_q[PAGE][29:16]}, 32'h3FFF);
    check("big page1 cfg", wr_q[PAGE + 1], {2'h0, 14'h0006, 16'h0001});
    check("big first_word_page1 addr", {18'h0, wr_q[PAGE + 2][29:16]}, 0);
    checkOutput("big", MAX + 1, 65535, 1, 32768, 2, stalls);
    repeat (3) @(negedge clk);
    check("overflow sticky", {31'h0, bus.OVERFLOW}, 1);
    bytes[0] = 8'h5A; bytes[1] = 8'hA5;
    applyStimulus(2, 0, 0, 0, stalls);
    checkOutput("after_ovf", 2, 1, 0, 1, 1, stalls);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_bram_writer.md
Name: mod_bram_writer

Overview:
Writer side of the modulation buffer path. It accepts a byte stream of modulation samples and packs two samples per 16-bit word. It writes the words into the modulation BRAM through a 14-bit windowed address, and it programs the page-offset register in the config BRAM whenever the window must move. On completion it publishes MOD_CYCLE (sample count minus one) for the modulation sampler.

Parameters:
BRAM_CONFIG_SELECT, 2'h0, BRAM_SELECT code for the config BRAM.
BRAM_MOD_SELECT, 2'h1, BRAM_SELECT code for the modulation BRAM.
MOD_BRAM_ADDR_OFFSET_ADDR, 14'h0006, config BRAM address of the modulation page-offset register.
MAX_SAMPLES, 65536, capacity in samples; must be a power of two, at most 65536.

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
START  in  1  one-cycle pulse; begin a new sequence (honoured only in IDLE)
DIN  in  8  sample byte
DIN_VALID  in  1  DIN valid
DIN_LAST  in  1  marks the final sample byte; qualified by DIN_VALID
DIN_READY  out  1  writer accepts DIN this cycle
BRAM_WE  out  1  write strobe
BRAM_SELECT  out  2  target BRAM code
BRAM_ADDR  out  14  word address
BRAM_DATA  out  16  write data
MOD_CYCLE  out  16  samples written minus one; valid after DONE
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse at sequence end
OVERFLOW  out  1  sticky flag; cleared on START

Behaviour:
- Reset: state IDLE. DIN_READY, BRAM_WE, BRAM_SELECT, BRAM_ADDR, BRAM_DATA, MOD_CYCLE, BUSY, DONE and OVERFLOW all reset to 0. Sample counter (17 bit), page and low-byte hold register clear.
- A byte is accepted when DIN_VALID and DIN_READY are both high. DIN_READY is high only in STREAM.
- All BRAM outputs are registered. A write occurs in the cycle after its cause. BRAM_WE is high for exactly one cycle per write.
- State IDLE:
  - START clears the counter, page and OVERFLOW, then goes to SET_PAGE.
  - START in any other state is ignored.
- State SET_PAGE (1 cycle): writes BRAM_SELECT=BRAM_CONFIG_SELECT, ADDR=MOD_BRAM_ADDR_OFFSET_ADDR, DATA=page zero-extended. Then goes to STREAM.
- State STREAM, on an accepted byte at count n:
  - n even: hold the byte as the low byte; no write.
  - n odd: write BRAM_SELECT=BRAM_MOD_SELECT, ADDR=(n>>1)[13:0], DATA={DIN, held}. Sample 2k sits in [7:0] and sample 2k+1 in [15:8].
  - count increments by one.
- Page crossing: if the accepted byte completes word address 14'h3FFF and is not LAST, then in the same cycle page increments and the next state is SET_PAGE. DIN_READY is therefore low for exactly one cycle before streaming resumes.
- DIN_LAST accepted:
  - Final count odd (trailing unpaired byte): go to FLUSH, which writes DATA={8'h00, held} at ADDR=(n>>1)[13:0]. Then go to FIN.
  - Final count even: go straight to FIN.
  - A LAST that coincides with a page-crossing byte skips SET_PAGE.
- State FIN (1 cycle): DONE=1, MOD_CYCLE=count-1 (low 16 bits), then IDLE. MOD_CYCLE holds its value until the next FIN or RST.
- Overflow: a byte accepted when count==MAX_SAMPLES sets OVERFLOW.
  - No write occurs and the counter saturates.
  - Bytes keep being accepted and discarded until LAST.
  - MOD_CYCLE becomes MAX_SAMPLES-1.
  - No page advance happens beyond the last page.
- Simultaneous events: START together with DIN_VALID in IDLE only starts the sequence; DIN_READY is 0, so no byte is consumed.
- RST mid-sequence: forces IDLE and all outputs to their reset values. Partially written BRAM contents are not restored. MOD_CYCLE returns to 0.
- Throughput: one byte per cycle in STREAM, except one stall cycle per page crossing.

Test Plan:
- RST, then START, then 4 bytes 11,22,33,44 with LAST on 44 -> config write ADDR 14'h0006 DATA 0; mod writes ADDR0=16'h2211 and ADDR1=16'h4433; DONE pulse; MOD_CYCLE=3.
- Odd length: 3 bytes AA,BB,CC with LAST -> ADDR0=16'hBBAA; flush ADDR1=16'h00CC; MOD_CYCLE=2.
- Page crossing: 32770 bytes streamed continuously -> word 16383 written at 14'h3FFF; DIN_READY low for one cycle; config write DATA=1; next word at ADDR 0; MOD_CYCLE=32769.
- Overflow: 65537 bytes with LAST on the final byte -> OVERFLOW=1; 32768 mod writes total; MOD_CYCLE=65535; the next START clears OVERFLOW.
- Backpressure and idle gaps: random DIN_VALID gaps, plus START pulses while BUSY -> same BRAM contents as the continuous case; extra STARTs have no effect.
- RST asserted mid-stream after 5 bytes -> the next cycle shows IDLE, BUSY=0, BRAM_WE=0, MOD_CYCLE=0; a new START restarts at page 0, ADDR 0.
